// File: rtl/ncl_pkg.sv
// rtl/ncl_pkg.sv - shared NCL encodings and dual-rail helper functions
package ncl_pkg;

   localparam int NCL_RST_NULL  = 0;
   localparam int NCL_RST_DATA0 = 1;
   localparam int NCL_RST_DATA1 = 2;

   localparam int NCL_MAX_WIDTH = 64;
   typedef logic [NCL_MAX_WIDTH-1:0] ncl_vec_t;

   function automatic logic is_null(input ncl_vec_t t, input ncl_vec_t f);
      return (t | f) == '0;
   endfunction

   // Narrower words are passed zero-extended; only the low width bits must be valid.
   function automatic logic is_data(input ncl_vec_t t, input ncl_vec_t f, input int width);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < NCL_MAX_WIDTH; i++) begin
         if (i < width && !(t[i] ^ f[i])) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/ncl_thmn_gate.sv
// rtl/ncl_thmn_gate.sv - clocked hysteretic THmn threshold gate
module ncl_thmn_gate #(
   parameter int   M       = 2,
   parameter int   N       = 2,
   parameter logic RESET_Q = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] a,
   input  logic         hold,
   output logic         q
);

   // Sets at M-of-N ones, clears only when every input is 0, otherwise keeps state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_Q;
      end else if (!hold) begin
         if ($countones(a) >= M) q <= 1'b1;
         else if (a == '0)       q <= 1'b0;
      end
   end

endmodule

// File: rtl/ncl_dr_reg_stage.sv
// rtl/ncl_dr_reg_stage.sv - NCL dual-rail register stage with completion detection
module ncl_dr_reg_stage import ncl_pkg::*; #(
   parameter int WIDTH         = 8,
   parameter int RESET_VAL     = NCL_RST_NULL,
   parameter int CHECK_ILLEGAL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_t,
   input  logic [WIDTH-1:0] d_f,
   input  logic             ki,
   output logic [WIDTH-1:0] q_t,
   output logic [WIDTH-1:0] q_f,
   output logic             ko,
   output logic             err,
   input  logic             err_clr
);

   localparam logic RST_T    = (RESET_VAL == NCL_RST_DATA1);
   localparam logic RST_F    = (RESET_VAL == NCL_RST_DATA0);
   localparam logic RST_DONE = (RESET_VAL != NCL_RST_NULL);

   logic [WIDTH-1:0] illegal;
   logic [WIDTH-1:0] v;
   logic             done;

   assign illegal = d_t & d_f;
   assign v       = q_t | q_f;
   assign ko      = ~done;

   // A rail may not rise while its partner is high, so q_t/q_f are never both 1
   // even if upstream skips the NULL wavefront; the interlock is independent of err reporting.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      ncl_thmn_gate #(.M(2), .N(2), .RESET_Q(RST_T)) u_rail_t (
         .clk   (clk),
         .rst_n (rst_n),
         .a     ({d_t[i], ki}),
         .hold  (illegal[i] | q_f[i]),
         .q     (q_t[i])
      );
      ncl_thmn_gate #(.M(2), .N(2), .RESET_Q(RST_F)) u_rail_f (
         .clk   (clk),
         .rst_n (rst_n),
         .a     ({d_f[i], ki}),
         .hold  (illegal[i] | q_t[i]),
         .q     (q_f[i])
      );
   end

   ncl_thmn_gate #(.M(WIDTH), .N(WIDTH), .RESET_Q(RST_DONE)) u_done (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (v),
      .hold  (1'b0),
      .q     (done)
   );

   if (CHECK_ILLEGAL != 0) begin : g_err
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)        err <= 1'b0;
         else if (|illegal) err <= 1'b1;
         else if (err_clr)  err <= 1'b0;
      end
   end else begin : g_no_err
      assign err = 1'b0;
   end

endmodule
